// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the serial adder datapath (controller and result collector).
package serial_adder_pkg;

  localparam int unsigned SER_WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    CARRY = 2'b10,
    HOLD  = 2'b11
  } state_e;

  // Running parity: the first bit of a word restarts the accumulation.
  function automatic logic parity_next(input logic start, input logic par, input logic b);
    if (start) begin
      parity_next = b;
    end else begin
      parity_next = par ^ b;
    end
  endfunction

endpackage

// File: rtl/serial_sipo_reg.sv
// LSB-first serial-in/parallel-out register with synchronous clear.
// With SERIAL_COLLECT_PARITY_EN defined it also keeps a running parity of shifted bits.
module serial_sipo_reg
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = SER_WIDTH_DEFAULT
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             clr_i,
  input  logic             shift_en_i,
  input  logic             start_i,
  input  logic             bit_i,
`ifdef SERIAL_COLLECT_PARITY_EN
  output logic             parity_o,
`endif
  output logic [WIDTH-1:0] shreg_o
);

  logic [WIDTH-1:0] shreg_q;
  logic [WIDTH-1:0] shreg_d;

  // New bits enter at the top so the first received bit ends up in bit 0.
  always_comb begin
    shreg_d = shreg_q;
    if (clr_i) begin
      shreg_d = {WIDTH{1'b0}};
    end else if (shift_en_i) begin
      shreg_d = {bit_i, shreg_q[WIDTH-1:1]};
    end else begin
      shreg_d = shreg_q;
    end
  end

  // Shift register state.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      shreg_q <= {WIDTH{1'b0}};
    end else begin
      shreg_q <= shreg_d;
    end
  end

  assign shreg_o = shreg_q;

`ifdef SERIAL_COLLECT_PARITY_EN
  logic parity_q;
  logic parity_d;

  // Parity accumulator follows the same clear/shift qualification as the data.
  always_comb begin
    parity_d = parity_q;
    if (clr_i) begin
      parity_d = 1'b0;
    end else if (shift_en_i) begin
      parity_d = parity_next(start_i, parity_q, bit_i);
    end else begin
      parity_d = parity_q;
    end
  end

  // Parity accumulator state.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= parity_d;
    end
  end

  assign parity_o = parity_q;
`endif

endmodule

// File: rtl/serial_result_collector.sv
// Collects the LSB-first sum bitstream and final carry into a parallel word on a valid/ready port.
// Optional RES_PARITY output is enabled with the SERIAL_COLLECT_PARITY_EN macro.
module serial_result_collector
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = SER_WIDTH_DEFAULT
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             SER_EN,
  input  logic             SER_LOAD,
  input  logic             SER_BIT,
  input  logic             SER_CARRY,
  output logic [WIDTH-1:0] RES_DATA,
  output logic             RES_COUT,
`ifdef SERIAL_COLLECT_PARITY_EN
  output logic             RES_PARITY,
`endif
  output logic             RES_VALID,
  input  logic             RES_READY,
  output logic             BUSY,
  output logic             OVERRUN
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] res_data_q, res_data_d;
  logic             res_cout_q, res_cout_d;
  logic             res_valid_q, res_valid_d;
  logic             busy_q, busy_d;
  logic             overrun_q, overrun_d;

  logic             acc_s;
  logic             sh_en_s;
  logic             sh_start_s;
  logic             sh_clr_s;
  logic [WIDTH-1:0] shreg_s;

  assign acc_s = SER_EN & ~SER_LOAD;

`ifdef SERIAL_COLLECT_PARITY_EN
  logic res_parity_q, res_parity_d;
  logic parity_s;
`endif

  serial_sipo_reg #(
    .WIDTH(WIDTH)
  ) u_sipo (
    .CLK       (CLK),
    .RST       (RST),
    .clr_i     (sh_clr_s),
    .shift_en_i(sh_en_s),
    .start_i   (sh_start_s),
    .bit_i     (SER_BIT),
`ifdef SERIAL_COLLECT_PARITY_EN
    .parity_o  (parity_s),
`endif
    .shreg_o   (shreg_s)
  );

  // Next-state, counter and result register logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    res_data_d  = res_data_q;
    res_cout_d  = res_cout_q;
    res_valid_d = res_valid_q;
    overrun_d   = overrun_q;
    sh_en_s     = 1'b0;
    sh_start_s  = 1'b0;
    sh_clr_s    = 1'b0;
`ifdef SERIAL_COLLECT_PARITY_EN
    res_parity_d = res_parity_q;
`endif

    case (state_q)
      IDLE: begin
        if (acc_s) begin
          sh_en_s    = 1'b1;
          sh_start_s = 1'b1;
          cnt_d      = CNT_ONE;
          state_d    = (cnt_d == CNT_FULL) ? CARRY : SHIFT;
        end else if (SER_LOAD) begin
          overrun_d = 1'b0;
          state_d   = IDLE;
        end else begin
          state_d = IDLE;
        end
      end

      SHIFT: begin
        // Any gap in the window before the word is complete discards it.
        if (acc_s) begin
          sh_en_s = 1'b1;
          cnt_d   = cnt_q + CNT_ONE;
          state_d = (cnt_d == CNT_FULL) ? CARRY : SHIFT;
        end else begin
          sh_clr_s = 1'b1;
          cnt_d    = CNT_ZERO;
          state_d  = IDLE;
        end
      end

      CARRY: begin
        res_data_d  = shreg_s;
        res_cout_d  = SER_CARRY;
        res_valid_d = 1'b1;
        cnt_d       = CNT_ZERO;
        state_d     = HOLD;
`ifdef SERIAL_COLLECT_PARITY_EN
        res_parity_d = parity_s;
`endif
      end

      HOLD: begin
        if (RES_READY) begin
          res_valid_d = 1'b0;
          if (acc_s) begin
            sh_en_s    = 1'b1;
            sh_start_s = 1'b1;
            cnt_d      = CNT_ONE;
            state_d    = (cnt_d == CNT_FULL) ? CARRY : SHIFT;
          end else begin
            state_d = IDLE;
          end
        end else if (acc_s) begin
          overrun_d = 1'b1;
          state_d   = HOLD;
        end else begin
          state_d = HOLD;
        end
      end

      default: begin
        sh_clr_s    = 1'b1;
        cnt_d       = CNT_ZERO;
        res_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase

    busy_d = (state_d == SHIFT) || (state_d == CARRY);
  end

  // State and output registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= IDLE;
      cnt_q       <= CNT_ZERO;
      res_data_q  <= {WIDTH{1'b0}};
      res_cout_q  <= 1'b0;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      res_data_q  <= res_data_d;
      res_cout_q  <= res_cout_d;
      res_valid_q <= res_valid_d;
      busy_q      <= busy_d;
      overrun_q   <= overrun_d;
    end
  end

`ifdef SERIAL_COLLECT_PARITY_EN
  // Parity of the held word, captured alongside RES_DATA.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      res_parity_q <= 1'b0;
    end else begin
      res_parity_q <= res_parity_d;
    end
  end

  assign RES_PARITY = res_parity_q;
`endif

  assign RES_DATA  = res_data_q;
  assign RES_COUT  = res_cout_q;
  assign RES_VALID = res_valid_q;
  assign BUSY      = busy_q;
  assign OVERRUN   = overrun_q;

endmodule

// File: tb/tb_serial_result_collector.sv
// Self-checking bench for serial_result_collector: directed scenarios plus random traffic,
// compared every cycle against a bit-queue reference model.
module tb_serial_result_collector;

  localparam int W = 8;

  logic         CLK;
  logic         RST;
  logic         SER_EN;
  logic         SER_LOAD;
  logic         SER_BIT;
  logic         SER_CARRY;
  logic [W-1:0] RES_DATA;
  logic         RES_COUT;
  logic         RES_VALID;
  logic         RES_READY;
  logic         BUSY;
  logic         OVERRUN;
`ifdef SERIAL_COLLECT_PARITY_EN
  logic         RES_PARITY;
`endif

  int total = 0;
  int bad   = 0;

  // Reference model: bits of the word in progress, in arrival order.
  bit           m_bits[$];
  bit           m_carry_pend;
  bit           m_held;
  bit           m_overrun;
  logic [W-1:0] m_data;
  bit           m_cout;

  serial_result_collector #(.WIDTH(W)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .SER_EN    (SER_EN),
    .SER_LOAD  (SER_LOAD),
    .SER_BIT   (SER_BIT),
    .SER_CARRY (SER_CARRY),
    .RES_DATA  (RES_DATA),
    .RES_COUT  (RES_COUT),
`ifdef SERIAL_COLLECT_PARITY_EN
    .RES_PARITY(RES_PARITY),
`endif
    .RES_VALID (RES_VALID),
    .RES_READY (RES_READY),
    .BUSY      (BUSY),
    .OVERRUN   (OVERRUN)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] pack_bits();
    logic [W-1:0] v;
    v = '0;
    foreach (m_bits[i]) v[i] = m_bits[i];
    return v;
  endfunction

  task automatic model_clear();
    m_bits.delete();
    m_carry_pend = 1'b0;
    m_held       = 1'b0;
    m_overrun    = 1'b0;
    m_data       = '0;
    m_cout       = 1'b0;
  endtask

  task automatic model_edge(input bit en, input bit ld, input bit b, input bit cy, input bit rdy);
    bit acc;
    acc = en && !ld;
    if (m_carry_pend) begin
      m_data       = pack_bits();
      m_cout       = cy;
      m_held       = 1'b1;
      m_carry_pend = 1'b0;
      m_bits.delete();
    end else if (m_held) begin
      if (rdy) begin
        m_held = 1'b0;
        if (acc) m_bits.push_back(b);
      end else if (acc) begin
        m_overrun = 1'b1;
      end
    end else if (acc) begin
      m_bits.push_back(b);
      if (m_bits.size() == W) m_carry_pend = 1'b1;
    end else if (m_bits.size() > 0) begin
      m_bits.delete();
    end else if (ld) begin
      m_overrun = 1'b0;
    end
  endtask

  task automatic check_outputs();
    check("RES_VALID", 32'(RES_VALID), 32'(m_held));
    check("RES_DATA",  32'(RES_DATA),  32'(m_data));
    check("RES_COUT",  32'(RES_COUT),  32'(m_cout));
    check("BUSY",      32'(BUSY),      32'(m_bits.size() > 0 || m_carry_pend));
    check("OVERRUN",   32'(OVERRUN),   32'(m_overrun));
`ifdef SERIAL_COLLECT_PARITY_EN
    check("RES_PARITY", 32'(RES_PARITY), 32'(^m_data));
`endif
  endtask

  task automatic step(input bit en, input bit ld, input bit b, input bit cy, input bit rdy);
    SER_EN    = en;
    SER_LOAD  = ld;
    SER_BIT   = b;
    SER_CARRY = cy;
    RES_READY = rdy;
    @(posedge CLK);
    model_edge(en, ld, b, cy, rdy);
    #1;
    check_outputs();
  endtask

  task automatic send_bits(input logic [W-1:0] v, input int n, input bit cy, input bit rdy);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, v[i], cy, rdy);
  endtask

  // Asynchronous reset asserted between edges; outputs must clear before the next edge.
  task automatic do_reset();
    #2;
    RST = 1'b0;
    #1;
    model_clear();
    check_outputs();
    @(posedge CLK);
    #1;
    RST = 1'b1;
  endtask

  initial begin
    RST = 1'b0;
    SER_EN = 1'b0; SER_LOAD = 1'b0; SER_BIT = 1'b0; SER_CARRY = 1'b0; RES_READY = 1'b0;
    model_clear();
    #3;
    check_outputs();
    @(posedge CLK);
    #1;
    RST = 1'b1;

    // 0xA5 with carry, consumer always ready.
    send_bits(8'hA5, W, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    check("a5_data", 32'(RES_DATA), 32'h0000_00A5);
    check("a5_cout", 32'(RES_COUT), 32'h0000_0001);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // 0x3C held under back-pressure.
    send_bits(8'h3C, W, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("3c_held", 32'(RES_DATA), 32'h0000_003C);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Abort after 4 bits, then a full 0xFF word.
    send_bits(8'h0F, 4, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    send_bits(8'hFF, W, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("ff_data", 32'(RES_DATA), 32'h0000_00FF);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Back-to-back: first bit of 0x80 on the handshake edge.
    send_bits(8'h01, W, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    send_bits(8'h80, W, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    check("b2b_data", 32'(RES_DATA), 32'h0000_0080);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Same, but consumer stalls: second word dropped, OVERRUN set, cleared by LOAD in IDLE.
    send_bits(8'h01, W, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    send_bits(8'h80, W, 1'b1, 1'b0);
    check("ovr_data", 32'(RES_DATA), 32'h0000_0001);
    check("ovr_flag", 32'(OVERRUN), 32'h0000_0001);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

    // Reset mid-word and during HOLD.
    send_bits(8'h5A, 5, 1'b0, 1'b1);
    do_reset();
    send_bits(8'hC3, W, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    do_reset();
    send_bits(8'h07, W, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("post_rst_data", 32'(RES_DATA), 32'h0000_0007);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Random traffic: mostly-open serial window, occasional load/gaps, random back-pressure.
    for (int i = 0; i < 4000; i++) begin
      step(bit'($urandom_range(0, 9) != 0), bit'($urandom_range(0, 19) == 0),
           bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
           bit'($urandom_range(0, 2) != 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
